// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2
    } fetch_state_t;

    // Wide enough for the longest memory latency of 7 cycles.
    localparam int LAT_CNT_W = 3;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC arithmetic: sequential increment and branch destination.
module pc_next_calc #(
    parameter int PC_W   = 8,
    parameter int DATA_W = 16
) (
    input  logic [PC_W-1:0]   pc,
    input  logic              branch_rel,
    input  logic [PC_W-1:0]   branch_target,
    input  logic [DATA_W-1:0] sximm,
    output logic [PC_W-1:0]   pc_inc,
    output logic [PC_W-1:0]   branch_dest
);

    // Modulo-2^PC_W addition makes the truncated offset behave as sign-extended.
    logic [PC_W-1:0] offset;

    assign offset      = sximm[PC_W-1:0];
    assign pc_inc      = pc + PC_W'(1);
    assign branch_dest = branch_rel ? (pc + offset) : branch_target;

    generate
        if (DATA_W > PC_W) begin : g_sximm_hi
            logic unused_sximm_hi;
            assign unused_sximm_hi = ^sximm[DATA_W-1:PC_W];
        end
    endgenerate

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: fixed-latency memory read, IR load and PC update
// with a single pending-branch register for redirects that arrive while busy.
//
// state | meaning
// IDLE  | waiting for fetch_req or branch_en; branch applies to pc directly
// FETCH | mem_rd held, latency counter counting down to zero
// LOAD  | one cycle; ir/pc were updated on entry, ir_valid high
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int PC_W     = 8,
    parameter int DATA_W   = 16,
    parameter int MEM_LAT  = 1,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic              halt,
    input  logic              branch_en,
    input  logic              branch_rel,
    input  logic [PC_W-1:0]   branch_target,
    input  logic [DATA_W-1:0] sximm,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [PC_W-1:0]   mem_addr,
    output logic              mem_rd,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    output logic [PC_W-1:0]   pc,
    output logic              busy
);

    fetch_state_t         state;
    fetch_state_t         state_next;
    logic [LAT_CNT_W-1:0] lat_cnt;
    logic                 pending_valid;
    logic [PC_W-1:0]      pending_pc;
    logic [PC_W-1:0]      pc_inc;
    logic [PC_W-1:0]      branch_dest;
    logic                 accept;
    logic                 load_entry;

    pc_next_calc #(
        .PC_W   (PC_W),
        .DATA_W (DATA_W)
    ) u_pc_next_calc (
        .pc            (pc),
        .branch_rel    (branch_rel),
        .branch_target (branch_target),
        .sximm         (sximm),
        .pc_inc        (pc_inc),
        .branch_dest   (branch_dest)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        load_entry = 1'b0;
        case (state)
            IDLE: begin
                // A branch in IDLE wins over a simultaneous fetch request.
                if (!branch_en && fetch_req && !halt) begin
                    state_next = FETCH;
                    accept     = 1'b1;
                end
            end
            FETCH: begin
                if (lat_cnt == '0) begin
                    state_next = LOAD;
                    load_entry = 1'b1;
                end
            end
            LOAD: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc            <= PC_W'(RESET_PC);
            mem_addr      <= PC_W'(RESET_PC);
            mem_rd        <= 1'b0;
            ir            <= '0;
            ir_valid      <= 1'b0;
            lat_cnt       <= '0;
            pending_valid <= 1'b0;
            pending_pc    <= '0;
        end else begin
            ir_valid <= 1'b0;

            if (accept) begin
                mem_addr <= pc;
                mem_rd   <= 1'b1;
                lat_cnt  <= LAT_CNT_W'(MEM_LAT - 1);
            end else if (state == FETCH && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - LAT_CNT_W'(1);
            end

            // A branch arriving on the LOAD-entry edge is newest, so it beats the pending one.
            if (load_entry) begin
                mem_rd        <= 1'b0;
                ir            <= mem_rdata;
                ir_valid      <= 1'b1;
                pending_valid <= 1'b0;
                if (branch_en) begin
                    pc <= branch_dest;
                end else if (pending_valid) begin
                    pc <= pending_pc;
                end else begin
                    pc <= pc_inc;
                end
            end else if (branch_en) begin
                if (state == IDLE) begin
                    pc            <= branch_dest;
                    pending_valid <= 1'b0;
                end else begin
                    pending_valid <= 1'b1;
                    pending_pc    <= branch_dest;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed scenarios plus random traffic
// checked against a transaction-level model of the fetch/branch behaviour.
module tb_instr_fetch_unit;

    localparam int PC_W     = 8;
    localparam int DATA_W   = 16;
    localparam int MEM_LAT  = 3;
    localparam int RESET_PC = 0;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              fetch_req = 1'b0;
    logic              halt = 1'b0;
    logic              branch_en = 1'b0;
    logic              branch_rel = 1'b0;
    logic [PC_W-1:0]   branch_target = '0;
    logic [DATA_W-1:0] sximm = '0;
    logic [DATA_W-1:0] mem_rdata;
    logic [PC_W-1:0]   mem_addr;
    logic              mem_rd;
    logic [DATA_W-1:0] ir;
    logic              ir_valid;
    logic [PC_W-1:0]   pc;
    logic              busy;

    logic [DATA_W-1:0] mem [256];

    assign mem_rdata = mem[mem_addr];

    instr_fetch_unit #(
        .PC_W     (PC_W),
        .DATA_W   (DATA_W),
        .MEM_LAT  (MEM_LAT),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_req     (fetch_req),
        .halt          (halt),
        .branch_en     (branch_en),
        .branch_rel    (branch_rel),
        .branch_target (branch_target),
        .sximm         (sximm),
        .mem_rdata     (mem_rdata),
        .mem_addr      (mem_addr),
        .mem_rd        (mem_rd),
        .ir            (ir),
        .ir_valid      (ir_valid),
        .pc            (pc),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] ir;
        logic [PC_W-1:0]   pc;
    } load_exp_t;

    typedef struct {
        bit              busy;
        bit              mem_rd;
        bit              ir_valid;
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] addr;
    } cycle_exp_t;

    load_exp_t  load_q[$];
    cycle_exp_t cycle_q[$];

    int checks = 0;
    int errors = 0;

    // Model state: remaining busy cycles of the current fetch (0 = idle).
    int m_pc      = RESET_PC;
    int m_left    = 0;
    int m_addr    = RESET_PC;
    bit m_pend_v  = 1'b0;
    int m_pend    = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int calc_target(input int cur, input bit rel, input logic [PC_W-1:0] abs_t,
                                       input logic [DATA_W-1:0] sx);
        int t;
        if (!rel) return int'(abs_t);
        t = (cur + int'($signed(sx))) % 256;
        if (t < 0) t += 256;
        return t;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        int tgt;
        cycle_exp_t c;
        load_exp_t  l;
        tgt = calc_target(m_pc, branch_rel, branch_target, sximm);
        if (m_left == 0) begin
            if (branch_en) begin
                m_pc     = tgt;
                m_pend_v = 1'b0;
            end else if (fetch_req && !halt) begin
                m_left = MEM_LAT + 1;
                m_addr = m_pc;
            end
        end else begin
            if (m_left == 2) begin
                if (branch_en)     m_pc = tgt;
                else if (m_pend_v) m_pc = m_pend;
                else               m_pc = (m_pc + 1) % 256;
                m_pend_v = 1'b0;
                l.ir = mem[m_addr];
                l.pc = m_pc[PC_W-1:0];
                load_q.push_back(l);
            end else if (branch_en) begin
                m_pend_v = 1'b1;
                m_pend   = tgt;
            end
            m_left--;
        end
        c.busy     = (m_left != 0);
        c.mem_rd   = (m_left >= 2);
        c.ir_valid = (m_left == 1);
        c.pc       = m_pc[PC_W-1:0];
        c.addr     = m_addr[PC_W-1:0];
        cycle_q.push_back(c);
    endtask

    task automatic model_reset();
        m_pc     = RESET_PC;
        m_left   = 0;
        m_addr   = RESET_PC;
        m_pend_v = 1'b0;
        m_pend   = 0;
    endtask

    task automatic step(input bit fr, input bit hl, input bit be, input bit br,
                        input logic [PC_W-1:0] bt, input logic [DATA_W-1:0] sx);
        @(negedge clk);
        fetch_req     = fr;
        halt          = hl;
        branch_en     = be;
        branch_rel    = br;
        branch_target = bt;
        sximm         = sx;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // Monitor: compares DUT outputs against queued expectations after each edge.
    always @(posedge clk) begin
        cycle_exp_t c;
        load_exp_t  l;
        #1;
        if (!rst) begin
            if (ir_valid) begin
                if (load_q.size() == 0) begin
                    chk("ir_valid_unexpected", 1, 0);
                end else begin
                    l = load_q.pop_front();
                    chk("load_ir", ir, l.ir);
                    chk("load_pc", pc, l.pc);
                end
            end
            if (cycle_q.size() != 0) begin
                c = cycle_q.pop_front();
                chk("cyc_busy", busy, c.busy);
                chk("cyc_mem_rd", mem_rd, c.mem_rd);
                chk("cyc_ir_valid", ir_valid, c.ir_valid);
                chk("cyc_pc", pc, c.pc);
                if (c.mem_rd) chk("cyc_mem_addr", mem_addr, c.addr);
            end
        end
    end

    initial begin
        int n;
        int lat;
        for (int i = 0; i < 256; i++) mem[i] = DATA_W'($urandom);
        mem[8'h00] = 16'hA5C3;

        #3;
        chk("rst_pc", pc, RESET_PC);
        chk("rst_ir", ir, 0);
        chk("rst_ir_valid", ir_valid, 0);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_addr", mem_addr, RESET_PC);
        chk("rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // First fetch right after reset, known instruction word
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        chk("first_accept_busy", busy, 1);
        lat = 1;
        while (!ir_valid && lat < 12) begin
            idle_step();
            lat++;
        end
        chk("fetch_latency", lat, MEM_LAT + 1);
        chk("first_ir", ir, 16'hA5C3);
        chk("first_pc", pc, 8'h01);
        idle_step();

        // Relative branch in IDLE beats a simultaneous fetch
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h10, '0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h77, 16'hFFFD);
        chk("rel_branch_pc", pc, 8'h0D);
        chk("rel_branch_busy", busy, 0);

        // Absolute branch during FETCH redirects the post-LOAD pc
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h05, '0);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h40, '0);
        repeat (MEM_LAT + 1) idle_step();
        chk("busy_branch_pc", pc, 8'h40);

        // Fetch at 0xFF wraps pc to 0x00; mem_rd lasts MEM_LAT cycles
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, '0);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (mem_rd) n++;
            idle_step();
        end
        chk("mem_rd_cycles", n, MEM_LAT);
        chk("wrap_pc", pc, 8'h00);

        // halt blocks acceptance; release starts the fetch on the next edge
        n = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
            if (busy) n++;
        end
        chk("halt_busy_cycles", n, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        chk("halt_release_busy", busy, 1);
        repeat (MEM_LAT + 1) idle_step();

        // Reset pulsed mid-FETCH aborts the fetch immediately
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        idle_step();
        rst = 1'b1;
        #1;
        chk("midrst_mem_rd", mem_rd, 0);
        chk("midrst_pc", pc, RESET_PC);
        chk("midrst_ir", ir, 0);
        chk("midrst_busy", busy, 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < MEM_LAT + 2; i++) begin
            idle_step();
            if (ir_valid) n++;
        end
        chk("midrst_no_ir_valid", n, 0);
        chk("midrst_ir_after", ir, 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 2),
                 ($urandom_range(0, 19) < 3), $urandom_range(0, 1),
                 PC_W'($urandom), DATA_W'($urandom));
        end
        repeat (MEM_LAT + 2) idle_step();
        #2;

        chk("load_queue_drained", load_q.size(), 0);
        chk("cycle_queue_drained", cycle_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
